// File: rtl/crossbar_pkg.sv
// Shared types for the crossbar request/grant arbiter.
// Default master count, master-id type and arbiter FSM states.
package crossbar_pkg;

    localparam int N_MASTERS_DEF = 16;
    localparam int ID_W_DEF      = $clog2(N_MASTERS_DEF);

    typedef logic [ID_W_DEF-1:0] master_id_t;

    typedef enum logic [1:0] {
        IDLE,
        GRANTED,
        GAP
    } arb_state_e;

endpackage

// File: rtl/crossbar_arbiter_rr_picker.sv
// Combinational rotating-priority picker.
// Ports: eligible vector, ptr (first index to scan) ->
//   winner_oh (one-hot), winner_id, any (eligible nonzero).
module rr_picker #(
    parameter int N    = 16,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    eligible,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    winner_oh,
    output logic [ID_W-1:0] winner_id,
    output logic            any
);

    // Scan ptr, ptr+1, ... wrapping at N; the first hit wins.
    always_comb begin
        int j;
        logic [ID_W-1:0] jj;
        winner_oh = '0;
        winner_id = '0;
        any       = 1'b0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr) + i;
            if (j >= N) j = j - N;
            jj = ID_W'(j);
            if (!any && eligible[jj]) begin
                any           = 1'b1;
                winner_oh[jj] = 1'b1;
                winner_id     = jj;
            end
        end
    end

endmodule

// File: rtl/crossbar_arbiter.sv
// Round-robin arbiter for the crossbar master-side path.
// In: request/req_mask per master, done/lock from the crossbar.
// Out: one-hot grant, grant_valid, grant_id, timeout_err/timeout_id.
module crossbar_arbiter
    import crossbar_pkg::*;
#(
    parameter int N_MASTERS = N_MASTERS_DEF,
    parameter int ID_W      = $clog2(N_MASTERS),
    parameter int TIMEOUT   = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_MASTERS-1:0] request,
    input  logic [N_MASTERS-1:0] req_mask,
    input  logic                 done,
    input  logic                 lock,
    output logic [N_MASTERS-1:0] grant,
    output logic                 grant_valid,
    output logic [ID_W-1:0]      grant_id,
    output logic                 timeout_err,
    output logic [ID_W-1:0]      timeout_id
);

    // A disabled watchdog still needs a legal 1-bit counter.
    localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0] WD_LAST =
        (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_MASTERS - 1);

    arb_state_e           state_q, state_d;
    logic [ID_W-1:0]      ptr_q, ptr_d;
    logic [WD_W-1:0]      wdog_q, wdog_d;
    logic [N_MASTERS-1:0] grant_q, grant_d;
    logic [ID_W-1:0]      id_q, id_d;
    logic                 terr_q, terr_d;
    logic [ID_W-1:0]      tid_q, tid_d;

    logic [N_MASTERS-1:0] eligible;
    logic [N_MASTERS-1:0] pick_oh;
    logic [ID_W-1:0]      pick_id;
    logic                 pick_any;

    assign eligible = request & req_mask;

    rr_picker #(
        .N    (N_MASTERS),
        .ID_W (ID_W)
    ) u_picker (
        .eligible  (eligible),
        .ptr       (ptr_q),
        .winner_oh (pick_oh),
        .winner_id (pick_id),
        .any       (pick_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            wdog_q  <= '0;
            grant_q <= '0;
            id_q    <= '0;
            terr_q  <= 1'b0;
            tid_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            wdog_q  <= wdog_d;
            grant_q <= grant_d;
            id_q    <= id_d;
            terr_q  <= terr_d;
            tid_q   <= tid_d;
        end
    end

    always_comb begin
        logic rel;
        state_d = state_q;
        ptr_d   = ptr_q;
        wdog_d  = wdog_q;
        grant_d = grant_q;
        id_d    = id_q;
        terr_d  = 1'b0;
        tid_d   = tid_q;
        rel     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_d = pick_oh;
                    id_d    = pick_id;
                    wdog_d  = '0;
                    state_d = GRANTED;
                end
            end
            GRANTED: begin
                // Ordering matters: abandon beats done, done beats
                // the watchdog, so neither raises a spurious error.
                if (!request[id_q] || !req_mask[id_q]) begin
                    rel = 1'b1;
                end else if (done && !lock) begin
                    rel = 1'b1;
                end else if (done && lock) begin
                    wdog_d = '0;
                end else if (TIMEOUT != 0 && wdog_q == WD_LAST) begin
                    rel    = 1'b1;
                    terr_d = 1'b1;
                    tid_d  = id_q;
                end else if (wdog_q != '1) begin
                    // Saturating, so a disabled watchdog never wraps.
                    wdog_d = wdog_q + 1'b1;
                end

                if (rel) begin
                    grant_d = '0;
                    id_d    = '0;
                    ptr_d   = (id_q == LAST_ID) ? '0 : id_q + 1'b1;
                    state_d = GAP;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign grant       = grant_q;
    assign grant_valid = |grant_q;
    assign grant_id    = id_q;
    assign timeout_err = terr_q;
    assign timeout_id  = tid_q;

endmodule

// File: tb/tb_crossbar_arbiter.sv
// Directed bench for crossbar_arbiter (16 masters, TIMEOUT=8).
// Hand-computed expectations; single chk task counts every compare.
module tb_crossbar_arbiter;
    import crossbar_pkg::*;

    localparam int N  = 16;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] request;
    logic [15:0] req_mask;
    logic        done;
    logic        lock;
    logic [15:0] grant;
    logic        grant_valid;
    master_id_t  grant_id;
    logic        timeout_err;
    master_id_t  timeout_id;

    int n_chk  = 0;
    int n_fail = 0;
    int n;

    always #5 clk = ~clk;

    crossbar_arbiter #(
        .N_MASTERS (N),
        .TIMEOUT   (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .request     (request),
        .req_mask    (req_mask),
        .done        (done),
        .lock        (lock),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .timeout_err (timeout_err),
        .timeout_id  (timeout_id)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_done(input logic l);
        done = 1'b1;
        lock = l;
        tick();
        done = 1'b0;
        lock = 1'b0;
    endtask

    task automatic wait_grant(input string tag, input int exp_id,
                              output int cnt);
        cnt = 0;
        while (!grant_valid && cnt < 20) begin
            tick();
            cnt++;
        end
        chk({tag, "_id"}, 32'(grant_id), 32'(exp_id));
        chk({tag, "_oh"}, 32'(grant), 32'd1 << exp_id);
    endtask

    // Grant must be zero/one-hot, and a fresh grant must hit E.
    logic [15:0] prev_e;
    logic [15:0] prev_g;
    always @(negedge clk) begin
        if (!rst) begin
            chk("onehot", 32'($onehot0(grant)), 32'd1);
            if (grant != 16'h0 && prev_g == 16'h0)
                chk("grant_in_e", 32'(|(grant & prev_e)), 32'd1);
        end
        prev_e = request & req_mask;
        prev_g = grant;
    end

    initial begin
        request  = '0;
        req_mask = 16'hFFFF;
        done     = 1'b0;
        lock     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_valid", 32'(grant_valid), 32'd0);
        chk("rst_id", 32'(grant_id), 32'd0);
        chk("rst_terr", 32'(timeout_err), 32'd0);
        chk("rst_tid", 32'(timeout_id), 32'd0);
        rst = 1'b0;
        tick();

        // 1: single request, latency 1, release, ptr -> 3
        request = 16'h0004;
        wait_grant("t1", 2, n);
        chk("t1_lat", 32'(n), 32'd1);
        chk("t1_valid", 32'(grant_valid), 32'd1);
        pulse_done(1'b0);
        chk("t1_rel", 32'(grant), 32'd0);
        chk("t1_rel_id", 32'(grant_id), 32'd0);
        request = 16'h000D;
        wait_grant("t1_ptr", 3, n);
        chk("t1_gap", 32'(n), 32'd2);
        pulse_done(1'b0);
        request = '0;

        // 2: all requesting, full rotation 0..15,0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        request = 16'hFFFF;
        for (int k = 0; k <= 16; k++) begin
            wait_grant($sformatf("t2_%0d", k), k % 16, n);
            if (k > 0) chk("t2_gap", 32'(n), 32'd2);
            pulse_done(1'b0);
        end
        request = '0;

        // 3: wrap-around from ptr 15
        request = 16'h4000;
        wait_grant("t3_14", 14, n);
        pulse_done(1'b0);
        request = 16'h8001;
        wait_grant("t3_15", 15, n);
        pulse_done(1'b0);
        request = 16'h0001;
        wait_grant("t3_0", 0, n);
        pulse_done(1'b0);
        request = '0;

        // 4: locked burst on master 5, then rotate upward
        request = 16'h0221;
        wait_grant("t4_5", 5, n);
        for (int k = 0; k < 3; k++) begin
            pulse_done(1'b1);
            chk("t4_lock", 32'(grant), 32'h0020);
            tick();
            chk("t4_hold", 32'(grant), 32'h0020);
        end
        pulse_done(1'b0);
        chk("t4_rel", 32'(grant), 32'd0);
        request = 16'h0201;
        wait_grant("t4_next", 9, n);
        pulse_done(1'b0);
        request = '0;

        // done outside GRANTED is ignored
        repeat (3) tick();
        pulse_done(1'b1);
        chk("idle_done", 32'(grant_valid), 32'd0);

        // 5: watchdog on master 3
        request = 16'h0018;
        wait_grant("t5", 3, n);
        for (int k = 0; k < TO - 1; k++) begin
            tick();
            chk("t5_hold", 32'(grant), 32'h0008);
            chk("t5_noerr", 32'(timeout_err), 32'd0);
        end
        tick();
        chk("t5_err", 32'(timeout_err), 32'd1);
        chk("t5_tid", 32'(timeout_id), 32'd3);
        chk("t5_drop", 32'(grant), 32'd0);
        tick();
        chk("t5_pulse", 32'(timeout_err), 32'd0);
        chk("t5_tid_hold", 32'(timeout_id), 32'd3);
        wait_grant("t5_next", 4, n);
        pulse_done(1'b0);
        request = '0;

        // done on the timeout cycle wins
        request = 16'h0040;
        wait_grant("t5b", 6, n);
        repeat (TO - 1) tick();
        pulse_done(1'b0);
        chk("t5b_drop", 32'(grant), 32'd0);
        chk("t5b_noerr", 32'(timeout_err), 32'd0);
        request = '0;

        // 6: abandon, masked request, reset mid-grant
        request = 16'h0080;
        wait_grant("t6", 7, n);
        repeat (2) tick();
        request = '0;
        tick();
        chk("t6_abandon", 32'(grant), 32'd0);
        chk("t6_noerr", 32'(timeout_err), 32'd0);
        req_mask = 16'hFFFE;
        request  = 16'h0001;
        repeat (12) tick();
        chk("t6_mask", 32'(grant_valid), 32'd0);
        req_mask = 16'hFFFF;
        wait_grant("t6_0", 0, n);
        tick();
        rst = 1'b1;
        #1;
        chk("t6_rst_grant", 32'(grant), 32'd0);
        chk("t6_rst_valid", 32'(grant_valid), 32'd0);
        tick();
        rst = 1'b0;
        wait_grant("t6_post", 0, n);
        chk("t6_post_lat", 32'(n), 32'd1);
        pulse_done(1'b0);
        request = '0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/crossbar_arbiter.md
Name: crossbar_arbiter

Overview:
Round-robin arbiter that shares the crossbar's single master-side path among up to 16 TileLink masters. It drives the crossbar's request/grant pair. It holds each grant for one complete transaction, or for a locked burst, then rotates priority. A watchdog revokes any grant whose transaction stalls, so one hung master cannot starve the others or the slaves (ROM, RAM, UART, zero page).

Parameters:
N_MASTERS, 16, number of requesters; valid range 2..16.
ID_W, $clog2(N_MASTERS), width of the master index.
TIMEOUT, 1024, cycles a grant may stay open without a done pulse; 0 disables the watchdog.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  reset; one clock; reset is asynchronous and active-high.
request  input  N_MASTERS  per-master bus request, level, held until served.
req_mask  input  N_MASTERS  1 = master may compete; quasi-static.
done  input  1  one-cycle pulse from the crossbar when the granted master's response (D channel) beat completes.
lock  input  1  sampled with done; 1 = keep the grant for another transaction.
grant  output  N_MASTERS  one-hot grant to the crossbar, or all zero.
grant_valid  output  1  OR of grant.
grant_id  output  ID_W  index of the granted master; 0 when grant_valid=0.
timeout_err  output  1  one-cycle pulse when the watchdog revokes a grant.
timeout_id  output  ID_W  index of the revoked master; valid with timeout_err, otherwise holds its last value.

Behaviour:
- Reset values:
  - grant=0, grant_valid=0, grant_id=0, timeout_err=0, timeout_id=0.
  - State=IDLE, priority pointer ptr=0, watchdog counter wdog=0.
- Eligible set E = request & req_mask.
- State IDLE:
  - If E≠0, the winner is the first set bit of E scanning ptr, ptr+1, … N_MASTERS-1, then 0 … ptr-1.
  - grant/grant_id are registered: they assert the cycle after E is first seen nonzero (latency 1).
  - Next state GRANTED, wdog=0.
  - If E=0, stay in IDLE.
- State GRANTED:
  - grant is stable; no re-arbitration takes place.
  - Exit conditions, in priority order:
    (a) request[winner]=0 or req_mask[winner]=0: abandon, release.
    (b) done=1 and lock=0: release.
    (c) done=1 and lock=1: stay in GRANTED, wdog=0.
    (d) TIMEOUT≠0 and wdog==TIMEOUT-1 without done: release, timeout_err=1, timeout_id=winner (registered with the release).
    Otherwise wdog increments.
- Release:
  - Next cycle grant=0, grant_valid=0, grant_id=0.
  - ptr=(winner+1) mod N_MASTERS, wrapping from N_MASTERS-1 to 0.
  - Next state GAP.
- State GAP:
  - Exactly one dead cycle, with grant=0, for bus turnaround.
  - Next state IDLE. New arbitration is evaluated in IDLE, so the minimum grant-to-grant spacing is 2 idle cycles.
- done or lock outside GRANTED are ignored.
- done coinciding with a timeout: done wins; no error is raised.
- Abandon coinciding with done: treated as a normal release; no error is raised.
- Grant is always zero or one-hot. A grant to a master outside E in IDLE is a bug; assert it in the bench.
- wdog width is $clog2(TIMEOUT+1) and it never wraps.
- Reset asserted mid-grant: grant drops asynchronously and all state returns to reset values.

Decomposition:
- Package crossbar_pkg:
  - N_MASTERS default constant.
  - master-id typedef (logic [ID_W-1:0]).
  - arb_state_e enum {IDLE, GRANTED, GAP}.
- Sub-module rr_picker: purely combinational. Inputs are the eligible vector and ptr; outputs are a one-hot winner, a winner index and an any flag.
- The crossbar_arbiter top keeps the FSM, ptr, watchdog and output registers.

Test Plan:
1. Reset, then request=16'h0004 → grant=16'h0004 and grant_id=2 one cycle later; done → grant=0 next cycle; ptr=3.
2. request=16'hFFFF, done after every grant → grant_id sequence 0,1,2,…,15,0, with a 2-cycle gap between grants and no master skipped.
3. ptr=15 after granting master 14, request=16'h8001 → master 15 granted first, then master 0 (wrap-around).
4. Master 5 granted; done with lock=1 three times → grant stays 16'h0020 throughout; then done with lock=0 → released, next grant goes to a master above 5.
5. TIMEOUT=8: master 3 granted, no done → on the 8th GRANTED cycle timeout_err pulses with timeout_id=3, grant drops next cycle, master 4 served next.
6. Master 7 granted; request[7] drops → released without timeout_err. Separately, req_mask=16'hFFFE with request=16'h0001 → no grant ever. Rst asserted mid-grant → grant=0 immediately.
